// File: rtl/mmio_responder_if.sv
// CPU data-memory bus as seen by the MMIO responder: command, address and write
// payload from the CPU, registered read result and read strobe back.
interface mmio_responder_if;
    logic [1:0]  mem_cmd;
    logic [8:0]  mem_addr;
    logic [15:0] write_data;
    logic [15:0] read_data;
    logic        rd_valid;

    modport master (
        output mem_cmd, mem_addr, write_data,
        input  read_data, rd_valid
    );

    modport slave (
        input  mem_cmd, mem_addr, write_data,
        output read_data, rd_valid
    );
endinterface

// File: rtl/mmio_responder.sv
// Memory-mapped I/O responder: LED and hex-display registers, synchronized switch
// port and a write counter, with a registered read path and one-cycle read strobe.
module mmio_responder (
    input  logic                    clk,
    input  logic                    reset,
    mmio_responder_if.slave         bus,
    input  logic [7:0]              SW,
    output logic [7:0]              LEDR,
    output logic [6:0]              HEX0,
    output logic [6:0]              HEX1,
    output logic [6:0]              HEX2,
    output logic [6:0]              HEX3
);

    typedef enum logic [1:0] {
        CMD_NONE  = 2'b00,
        CMD_READ  = 2'b01,
        CMD_WRITE = 2'b10,
        CMD_RSVD  = 2'b11
    } cmd_e;

    localparam logic [8:0] LED_ADDR = 9'h100;
    localparam logic [8:0] HEX_ADDR = 9'h101;
    localparam logic [8:0] SW_ADDR  = 9'h140;
    localparam logic [8:0] CNT_ADDR = 9'h141;

    logic [7:0]  led_q;
    logic [15:0] hex_q;
    logic [15:0] cnt_q;
    logic [7:0]  sw_s1;
    logic [7:0]  sw_s2;
    logic [15:0] read_data_q;
    logic        rd_valid_q;

    cmd_e        cmd;
    logic        rd_hit;
    logic [15:0] rd_mux;
    logic        wr_led;
    logic        wr_hex;

    assign cmd = cmd_e'(bus.mem_cmd);

    // NOTE: every combinational output gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        rd_hit = 1'b0;
        rd_mux = 16'h0000;
        unique case (bus.mem_addr)
            LED_ADDR: begin rd_hit = 1'b1; rd_mux = {8'h00, led_q}; end
            HEX_ADDR: begin rd_hit = 1'b1; rd_mux = hex_q;          end
            SW_ADDR:  begin rd_hit = 1'b1; rd_mux = {8'h00, sw_s2}; end
            CNT_ADDR: begin rd_hit = 1'b1; rd_mux = cnt_q;          end
            default:  ;
        endcase
    end

    assign wr_led = (cmd == CMD_WRITE) && (bus.mem_addr == LED_ADDR);
    assign wr_hex = (cmd == CMD_WRITE) && (bus.mem_addr == HEX_ADDR);

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values; a read therefore sees the register before a same-edge write.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            led_q       <= 8'h00;
            hex_q       <= 16'h0000;
            cnt_q       <= 16'h0000;
            sw_s1       <= 8'h00;
            sw_s2       <= 8'h00;
            read_data_q <= 16'h0000;
            rd_valid_q  <= 1'b0;
        end else begin
            sw_s1      <= SW;
            sw_s2      <= sw_s1;
            rd_valid_q <= 1'b0;

            if (wr_led) led_q <= bus.write_data[7:0];
            if (wr_hex) hex_q <= bus.write_data;
            // Counter wraps naturally at 16 bits
            if (wr_led || wr_hex) cnt_q <= cnt_q + 16'd1;

            if (cmd == CMD_READ && rd_hit) begin
                read_data_q <= rd_mux;
                rd_valid_q  <= 1'b1;
            end
        end
    end

    function automatic logic [6:0] seg7(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'h0: s = 7'b1000000;
            4'h1: s = 7'b1111001;
            4'h2: s = 7'b0100100;
            4'h3: s = 7'b0110000;
            4'h4: s = 7'b0011001;
            4'h5: s = 7'b0010010;
            4'h6: s = 7'b0000010;
            4'h7: s = 7'b1111000;
            4'h8: s = 7'b0000000;
            4'h9: s = 7'b0010000;
            4'hA: s = 7'b0001000;
            4'hB: s = 7'b0000011;
            4'hC: s = 7'b1000110;
            4'hD: s = 7'b0100001;
            4'hE: s = 7'b0000110;
            default: s = 7'b0001110;
        endcase
        return s;
    endfunction

    assign HEX0 = seg7(hex_q[3:0]);
    assign HEX1 = seg7(hex_q[7:4]);
    assign HEX2 = seg7(hex_q[11:8]);
    assign HEX3 = seg7(hex_q[15:12]);

    assign LEDR          = led_q;
    assign bus.read_data = read_data_q;
    assign bus.rd_valid  = rd_valid_q;

endmodule

// File: doc/mmio_responder.md
# mmio_responder

Memory-mapped I/O responder on the CPU data-memory bus (`mem_cmd`/`mem_addr`), sitting beside the RAM in the lab top level. It serves CPU writes to an LED register and a 4-digit hex display register, and CPU reads of the synchronized slide switches, both output registers and a write counter. Reads return data through a registered `read_data` plus `rd_valid` strobe; the top level uses `rd_valid` to steer the shared read bus.

## Interface
- `LED_ADDR`, 9'h100, LED register (R/W)
- `HEX_ADDR`, 9'h101, hex display register (R/W)
- `SW_ADDR`, 9'h140, switch port (RO)
- `CNT_ADDR`, 9'h141, write counter (RO)
- `clk` in 1: single clock, all state on rising edge
- `reset` in 1: asynchronous, active-low; asserted (0) forces all state to reset values immediately
- `mem_cmd` in 2: 2'b00 none, 2'b01 read, 2'b10 write, 2'b11 treated as none
- `mem_addr` in 9: request address
- `write_data` in 16: write payload
- `SW` in 8: raw asynchronous switch inputs
- `read_data` out 16: registered read result
- `rd_valid` out 1: high for one cycle when `read_data` carries a new mapped-read result
- `LEDR` out 8: LED register
- `HEX0`..`HEX3` out 7 each: active-low segments, bit6..bit0 = g..a, digit n shows hex register bits [4n+3:4n]

## Operation
- Request sampled at each rising edge; one command per cycle, no back-pressure.
- Write (`mem_cmd`=2'b10):
  - `LED_ADDR`: LED reg <= `write_data[7:0]`; cnt += 1
  - `HEX_ADDR`: hex reg <= `write_data[15:0]`; cnt += 1
  - `SW_ADDR`, `CNT_ADDR`, unmapped: ignored, cnt unchanged
- Read (`mem_cmd`=2'b01), `read_data` <=:
  - `LED_ADDR`: {8'h00, LED reg}
  - `HEX_ADDR`: hex reg
  - `SW_ADDR`: {8'h00, sw_s2}
  - `CNT_ADDR`: cnt
  - `rd_valid` <= 1 for mapped addresses.
  - Unmapped: `rd_valid` <= 0, `read_data` holds.
- No read: `rd_valid` <= 0, `read_data` holds last value.
- Switch synchronizer: sw_s1 <= `SW`, sw_s2 <= sw_s1 every cycle.
- cnt: 16-bit unsigned, wraps 16'hFFFF -> 16'h0000, no saturation or flag.
- Segment decoder (combinational from hex reg), active-low:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110

## Timing
- Reset values:
  - `read_data`=0, `rd_valid`=0, `LEDR`=0, hex reg=0 (`HEX0`..`HEX3`=7'b1000000)
  - cnt=0, sw_s1=sw_s2=0
- Write latency: command at edge N, `LEDR`/`HEX*` show new value after edge N.
- Read latency: command at edge N, `read_data` and `rd_valid` valid after edge N until edge N+1.
- Read of a register returns its value before edge N; an earlier write at edge N-1 is visible.
- Back-to-back reads: `rd_valid` stays high across consecutive mapped reads, with data updating every cycle.
- `SW` change before edge k: sw_s2 updates at edge k+1. A `SW_ADDR` read at edge k+2 or later returns the new value; a read at edge k+1 returns the old value.
- Reset asserted mid-operation: outputs return to reset values asynchronously. The first edge after deassertion processes the current request normally.

## Test plan
- Reset: hold `reset`=0 with `mem_cmd`=2'b10 to `LED_ADDR` -> `LEDR`=0, cnt=0, `rd_valid`=0, all `HEX*`=7'b1000000.
- LED write/read: write 16'hABCD to 9'h100, then read 9'h100 next cycle -> `LEDR`=8'hCD; `read_data`=16'h00CD with `rd_valid`=1 for exactly one cycle.
- Hex display: write 16'h1F0A to 9'h101 -> `HEX0`=0001000, `HEX1`=1000000, `HEX2`=0001110, `HEX3`=1111001; a read of 9'h101 returns 16'h1F0A.
- Switch sync: `SW`=8'h5A before edge k -> reads at k+1 return 16'h0000, reads at k+2 return 16'h005A.
- Counter and ignores:
  - 3 writes to `LED_ADDR`/`HEX_ADDR` plus writes to 9'h140, 9'h141, 9'h0FF -> cnt read = 16'h0003.
  - Unmapped read (9'h1FF) -> `rd_valid`=0, `read_data` unchanged.
- Wrap and async reset: 65537 LED writes -> cnt read = 16'h0001. Then assert `reset` between edges -> `read_data`=0 immediately, without waiting for a clock edge.
